// File: rtl/db_ptr_ctrl.sv
// Pointer, occupancy and ownership controller for the shared USB data buffer RAM.
// Optional registered almost_full watermark is built only when DB_CTRL_WATERMARK_EN is defined.
module db_ptr_ctrl #(
  parameter int DEPTH  = 64,
  parameter int PTR_W  = $clog2(DEPTH) + 1,
  parameter int DATA_W = 8
`ifdef DB_CTRL_WATERMARK_EN
  , parameter int AFULL_THRESH = 56
`endif
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              flush,
  input  logic              store_rx_data,
  input  logic [DATA_W-1:0] rx_byte,
  input  logic              store_tx_data,
  input  logic [DATA_W-1:0] tx_byte,
  input  logic              get_tx_data,
  input  logic              get_rx_data,
  output logic              buf_write_en,
  output logic [DATA_W-1:0] buf_write_data,
  output logic [PTR_W-1:0]  buf_write_ptr,
  output logic              buf_read_en,
  output logic [PTR_W-1:0]  buf_read_ptr,
  output logic [PTR_W-1:0]  buffer_occupancy,
  output logic [1:0]        buf_mode,
  output logic              overflow_err,
  output logic              underflow_err,
  output logic              almost_full
);

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_RX   = 2'b01,
    MODE_TX   = 2'b10
  } mode_e;

  mode_e             mode_q, mode_d;
  logic [PTR_W-1:0]  wptr_q, rptr_q, occ;
  logic              full, empty, kill;
  logic              wr_acc, rd_acc, wr_refused, rd_refused, wr_from_tx;

  assign occ   = wptr_q - rptr_q;
  assign full  = (occ == PTR_W'(DEPTH));
  assign empty = (occ == '0);
  assign kill  = clear | flush;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    wr_acc     = 1'b0;
    rd_acc     = 1'b0;
    wr_refused = 1'b0;
    rd_refused = 1'b0;
    wr_from_tx = 1'b0;
    mode_d     = mode_q;
    if (!kill) begin
      case (mode_q)
        MODE_IDLE: begin
          rd_refused = get_rx_data | get_tx_data;
          if (store_rx_data) begin
            wr_acc     = 1'b1;
            wr_refused = store_tx_data;  // simultaneous claim: RX side wins
            mode_d     = MODE_RX;
          end else if (store_tx_data) begin
            wr_acc     = 1'b1;
            wr_from_tx = 1'b1;
            mode_d     = MODE_TX;
          end
        end
        MODE_RX: begin
          wr_acc     = store_rx_data & ~full;
          wr_refused = (store_rx_data & full) | store_tx_data;
          rd_acc     = get_rx_data & ~empty;
          rd_refused = (get_rx_data & empty) | get_tx_data;
        end
        MODE_TX: begin
          wr_from_tx = 1'b1;
          wr_acc     = store_tx_data & ~full;
          wr_refused = (store_tx_data & full) | store_rx_data;
          rd_acc     = get_tx_data & ~empty;
          rd_refused = (get_tx_data & empty) | get_rx_data;
        end
        default: mode_d = MODE_IDLE;
      endcase
      // Ownership is released once the owner drains the last byte.
      if (mode_q != MODE_IDLE && rd_acc && !wr_acc && occ == PTR_W'(1))
        mode_d = MODE_IDLE;
    end
  end

  assign buf_write_en     = wr_acc;
  assign buf_write_data   = wr_from_tx ? tx_byte : rx_byte;
  assign buf_write_ptr    = wptr_q;
  assign buf_read_en      = rd_acc;
  assign buf_read_ptr     = rptr_q;
  assign buffer_occupancy = occ;
  assign buf_mode         = mode_q;

`ifdef DB_CTRL_WATERMARK_EN
  logic [PTR_W-1:0] occ_next;
  assign occ_next = occ + PTR_W'(wr_acc) - PTR_W'(rd_acc);
`else
  assign almost_full = 1'b0;
`endif

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      mode_q        <= MODE_IDLE;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
`ifdef DB_CTRL_WATERMARK_EN
      almost_full   <= 1'b0;
`endif
    end else if (kill) begin
      wptr_q <= '0;
      rptr_q <= '0;
      mode_q <= MODE_IDLE;
      if (clear) begin
        overflow_err  <= 1'b0;
        underflow_err <= 1'b0;
      end
`ifdef DB_CTRL_WATERMARK_EN
      almost_full <= 1'b0;
`endif
    end else begin
      if (wr_acc) wptr_q <= wptr_q + PTR_W'(1);
      if (rd_acc) rptr_q <= rptr_q + PTR_W'(1);
      mode_q <= mode_d;
      if (wr_refused) overflow_err  <= 1'b1;
      if (rd_refused) underflow_err <= 1'b1;
`ifdef DB_CTRL_WATERMARK_EN
      almost_full <= (occ_next >= PTR_W'(AFULL_THRESH));
`endif
    end
  end

endmodule
